axi_traffic_gen_leader: RTL and testbench
=========================================

AXI_TRAFFIC_GEN_LEADER -- requirements
Module: axi_traffic_gen_leader

Interface
REQ-001 Parameter ADDRWIDTH, default 32, AXI address width.
REQ-002 Parameter IDWIDTH, default 4, AXI ID width.
REQ-003 The AXI data width SHALL be fixed at 128 bits and the strobe width at 16 bits.
REQ-004 One clock and reset: clk_wr  in  1  sole clock; rst_wr_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  begins a test run; sampled only in IDLE.
REQ-006 base_addr  in  ADDRWIDTH  start address of the first burst.
REQ-007 burst_len  in  8  AXI LEN per burst (beats = burst_len+1).
REQ-008 num_bursts  in  8  burst count per run; 0 means no bursts.
REQ-009 busy  out  1  high from start acceptance until DONE.
REQ-010 done  out  1  high in DONE; cleared on the next accepted start.
REQ-011 pass  out  1  valid while done is high; 1 when err_count==0.
REQ-012 err_count  out  16  saturating error counter.
REQ-013 m_axi_aw{id,addr,len,size,burst,valid} out (IDWIDTH,ADDRWIDTH,8,3,2,1); m_axi_awready in 1.
REQ-014 m_axi_w{id,data,strb,last,valid} out (IDWIDTH,128,16,1,1); m_axi_wready in 1.
REQ-015 m_axi_b{id,resp,valid} in (IDWIDTH,2,1); m_axi_bready out 1.
REQ-016 m_axi_ar{id,addr,len,size,burst,valid} out (IDWIDTH,ADDRWIDTH,8,3,2,1); m_axi_arready in 1.
REQ-017 m_axi_r{id,data,resp,last,valid} in (IDWIDTH,128,2,1,1); m_axi_rready out 1.

Function
REQ-018 FSM states: IDLE, AW, W, B, AR, R, DONE.
REQ-019 IDLE->AW on start=1 with num_bursts!=0; IDLE->DONE on start=1 with num_bursts==0 (pass=1). start is ignored in all other states.
REQ-020 On start acceptance: latch base_addr, burst_len and num_bursts; clear err_count, burst index n and beat index k.
REQ-021 Burst address A(n) = base_addr + n*(burst_len+1)*16, modulo 2^ADDRWIDTH (wrap-around permitted).
REQ-022 Constant fields: awid/arid/wid = 0, awsize/arsize = 3'b100, awburst/arburst = 2'b01, wstrb = 16'hFFFF.
REQ-023 AW: awvalid=1 and awaddr=A(n); go to W on the cycle awvalid&&awready.
REQ-024 W: wvalid=1 and wdata = 4 copies of (A(n)+16*k)[31:0], zero-extended when ADDRWIDTH<32 and truncated when ADDRWIDTH>32; wlast=1 when k==burst_len. On each wvalid&&wready, increment k. On the last beat, clear k and go to B.
REQ-025 B: bready=1. On bvalid, if bresp!=0 or bid!=0, increment err_count. Then increment n; if n==num_bursts, clear n and go to AR, else go to AW.
REQ-026 AR: arvalid=1 and araddr=A(n); go to R on arvalid&&arready.
REQ-027 R: rready=1. For each rvalid beat, add exactly 1 to err_count if any of the following holds: rdata differs from the REQ-024 pattern, rresp!=0, rid!=0, or rlast!=(k==burst_len).
REQ-028 In R, the beat with k==burst_len ends the burst regardless of rlast: increment n, then go to DONE when n==num_bursts, else go to AR.
REQ-029 DONE: done=1 and busy=0; go to AW or DONE on a new start (per REQ-019), clearing done.
REQ-030 A valid, once asserted, SHALL hold with stable payload until its handshake; no combinational path from any ready to any valid.
REQ-031 At most one outstanding transaction at a time; AW and W are never concurrent.
REQ-032 err_count SHALL saturate at 16'hFFFF.
REQ-033 Unexpected bvalid/rvalid outside the B/R states SHALL be ignored (ready is low).

Reset
REQ-034 rst_wr_n=0 SHALL immediately force state IDLE and set every valid, bready, rready, busy, done, pass and err_count to 0, and every counter to 0, including mid-burst.
REQ-035 After reset release, the first start is accepted on the first rising edge of clk_wr with rst_wr_n=1.

Verification
REQ-036 base_addr=0x1000, burst_len=3, num_bursts=2, ideal slave memory -> AW at 0x1000 then 0x1040; first wdata=0x00001000 x4; 8 R beats match; done=1, pass=1, err_count=0.
REQ-037 Same run, slave returns bresp=2'b10 on burst 1 and flips rdata bit 0 on one beat -> err_count=2, pass=0.
REQ-038 Random ready back-pressure (0-5 idle cycles) on awready/wready/arready -> payload stays stable while valid is high; same result as REQ-036.
REQ-039 num_bursts=0 with start=1 -> DONE next cycle, pass=1, no AXI valid asserted.
REQ-040 rst_wr_n pulled low during the W beat k=2 -> all outputs 0 on the same edge; a fresh start completes with pass=1.
REQ-041 base_addr=0xFFFFFFE0, burst_len=1, num_bursts=2 -> second awaddr=0x00000000 (wrap); pass=1.

Source files
------------

// File: rtl/axi_traffic_gen_leader_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_traffic_gen_leader_if
// Brief    : AXI4 bus bundle (128-bit data) between traffic generator and slave
// Revision : 1.0
// ============================================================================
interface axi_traffic_gen_leader_if #(
  parameter int ADDRWIDTH = 32,
  parameter int IDWIDTH   = 4
);
  logic [IDWIDTH-1:0]   awid;
  logic [ADDRWIDTH-1:0] awaddr;
  logic [7:0]           awlen;
  logic [2:0]           awsize;
  logic [1:0]           awburst;
  logic                 awvalid;
  logic                 awready;

  logic [IDWIDTH-1:0]   wid;
  logic [127:0]         wdata;
  logic [15:0]          wstrb;
  logic                 wlast;
  logic                 wvalid;
  logic                 wready;

  logic [IDWIDTH-1:0]   bid;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;

  logic [IDWIDTH-1:0]   arid;
  logic [ADDRWIDTH-1:0] araddr;
  logic [7:0]           arlen;
  logic [2:0]           arsize;
  logic [1:0]           arburst;
  logic                 arvalid;
  logic                 arready;

  logic [IDWIDTH-1:0]   rid;
  logic [127:0]         rdata;
  logic [1:0]           rresp;
  logic                 rlast;
  logic                 rvalid;
  logic                 rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wid, wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wid, wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface
`default_nettype wire

// File: rtl/axi_traffic_gen_leader.sv
`default_nettype none
// ============================================================================
// Module   : axi_traffic_gen_leader
// Brief    : Writes address-pattern bursts over AXI, reads them back, counts errors
// Revision : 1.0
// ============================================================================
module axi_traffic_gen_leader #(
  parameter int ADDRWIDTH = 32,
  parameter int IDWIDTH   = 4
) (
  input  wire logic                 clk_wr,
  input  wire logic                 rst_wr_n,
  input  wire logic                 start,
  input  wire logic [ADDRWIDTH-1:0] base_addr,
  input  wire logic [7:0]           burst_len,
  input  wire logic [7:0]           num_bursts,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [15:0]               err_count,
  axi_traffic_gen_leader_if.master  m_axi
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_AW   = 3'd1;
  localparam logic [2:0] c_W    = 3'd2;
  localparam logic [2:0] c_B    = 3'd3;
  localparam logic [2:0] c_AR   = 3'd4;
  localparam logic [2:0] c_R    = 3'd5;
  localparam logic [2:0] c_DONE = 3'd6;

  localparam logic [ADDRWIDTH-1:0] c_BEAT_BYTES = ADDRWIDTH'(16);

  logic [2:0]           r_state;
  logic [ADDRWIDTH-1:0] r_base;
  logic [7:0]           r_len;
  logic [7:0]           r_num;
  logic [7:0]           r_n;
  logic [7:0]           r_k;
  logic [15:0]          r_err;
  logic [ADDRWIDTH-1:0] r_burst_addr;   // A(n)
  logic [ADDRWIDTH-1:0] r_beat_addr;    // A(n) + 16*k

  logic [ADDRWIDTH-1:0] w_stride;
  logic [ADDRWIDTH-1:0] w_next_burst;
  logic [31:0]          w_pat;
  logic                 w_last_beat;
  logic                 w_last_burst;
  logic                 w_b_bad;
  logic                 w_r_bad;
  logic [15:0]          w_err_inc;

  assign w_stride     = ADDRWIDTH'({({1'b0, r_len} + 9'd1), 4'b0000});
  assign w_next_burst = r_burst_addr + w_stride;
  assign w_pat        = 32'(r_beat_addr);
  assign w_last_beat  = (r_k == r_len);
  assign w_last_burst = ((r_n + 8'd1) == r_num);
  assign w_b_bad      = (m_axi.bresp != 2'b00) || (m_axi.bid != '0);
  assign w_r_bad      = (m_axi.rdata != {4{w_pat}}) || (m_axi.rresp != 2'b00) ||
                        (m_axi.rid != '0) || (m_axi.rlast != w_last_beat);
  assign w_err_inc    = (r_err == 16'hFFFF) ? r_err : r_err + 16'd1;

  // Valids decode straight from the state register, so ready never feeds valid.
  assign m_axi.awid    = '0;
  assign m_axi.awaddr  = r_burst_addr;
  assign m_axi.awlen   = r_len;
  assign m_axi.awsize  = 3'b100;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awvalid = (r_state == c_AW);

  assign m_axi.wid     = '0;
  assign m_axi.wdata   = {4{w_pat}};
  assign m_axi.wstrb   = 16'hFFFF;
  assign m_axi.wlast   = w_last_beat;
  assign m_axi.wvalid  = (r_state == c_W);

  assign m_axi.bready  = (r_state == c_B);

  assign m_axi.arid    = '0;
  assign m_axi.araddr  = r_burst_addr;
  assign m_axi.arlen   = r_len;
  assign m_axi.arsize  = 3'b100;
  assign m_axi.arburst = 2'b01;
  assign m_axi.arvalid = (r_state == c_AR);

  assign m_axi.rready  = (r_state == c_R);

  assign busy      = (r_state != c_IDLE) && (r_state != c_DONE);
  assign done      = (r_state == c_DONE);
  assign pass      = done && (r_err == 16'd0);
  assign err_count = r_err;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      r_state      <= c_IDLE;
      r_base       <= '0;
      r_len        <= '0;
      r_num        <= '0;
      r_n          <= '0;
      r_k          <= '0;
      r_err        <= '0;
      r_burst_addr <= '0;
      r_beat_addr  <= '0;
    end else begin
      case (r_state)
        c_IDLE, c_DONE: begin
          if (start) begin
            r_base       <= base_addr;
            r_len        <= burst_len;
            r_num        <= num_bursts;
            r_n          <= '0;
            r_k          <= '0;
            r_err        <= '0;
            r_burst_addr <= base_addr;
            r_beat_addr  <= base_addr;
            r_state      <= (num_bursts != 8'd0) ? c_AW : c_DONE;
          end
        end
        c_AW: begin
          if (m_axi.awready) r_state <= c_W;
        end
        c_W: begin
          if (m_axi.wready) begin
            if (w_last_beat) begin
              r_k     <= '0;
              r_state <= c_B;
            end else begin
              r_k         <= r_k + 8'd1;
              r_beat_addr <= r_beat_addr + c_BEAT_BYTES;
            end
          end
        end
        c_B: begin
          if (m_axi.bvalid) begin
            if (w_b_bad) r_err <= w_err_inc;
            if (w_last_burst) begin
              // Read-back pass restarts from the first burst address.
              r_n          <= '0;
              r_burst_addr <= r_base;
              r_beat_addr  <= r_base;
              r_state      <= c_AR;
            end else begin
              r_n          <= r_n + 8'd1;
              r_burst_addr <= w_next_burst;
              r_beat_addr  <= w_next_burst;
              r_state      <= c_AW;
            end
          end
        end
        c_AR: begin
          if (m_axi.arready) r_state <= c_R;
        end
        c_R: begin
          if (m_axi.rvalid) begin
            if (w_r_bad) r_err <= w_err_inc;
            if (w_last_beat) begin
              r_k <= '0;
              if (w_last_burst) begin
                r_n     <= '0;
                r_state <= c_DONE;
              end else begin
                r_n          <= r_n + 8'd1;
                r_burst_addr <= w_next_burst;
                r_beat_addr  <= w_next_burst;
                r_state      <= c_AR;
              end
            end else begin
              r_k         <= r_k + 8'd1;
              r_beat_addr <= r_beat_addr + c_BEAT_BYTES;
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_traffic_gen_leader.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_traffic_gen_leader
// Brief    : Randomised slave with memory plus reference model for the generator
// Revision : 1.0
// ============================================================================
module tb_axi_traffic_gen_leader;

  localparam int ADDRWIDTH = 32;
  localparam int IDWIDTH   = 4;
  localparam int TIMEOUT   = 500;

  logic                 clk_wr = 1'b0;
  logic                 rst_wr_n = 1'b0;
  logic                 start = 1'b0;
  logic [ADDRWIDTH-1:0] base_addr = '0;
  logic [7:0]           burst_len = '0;
  logic [7:0]           num_bursts = '0;
  logic                 busy, done, pass;
  logic [15:0]          err_count;

  int total = 0;
  int bad   = 0;
  bit aborted;
  logic [127:0] mem [bit [31:0]];

  axi_traffic_gen_leader_if #(.ADDRWIDTH(ADDRWIDTH), .IDWIDTH(IDWIDTH)) m_axi ();

  axi_traffic_gen_leader #(.ADDRWIDTH(ADDRWIDTH), .IDWIDTH(IDWIDTH)) dut (
    .clk_wr     (clk_wr),
    .rst_wr_n   (rst_wr_n),
    .start      (start),
    .base_addr  (base_addr),
    .burst_len  (burst_len),
    .num_bursts (num_bursts),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .m_axi      (m_axi)
  );

  always #5 clk_wr = ~clk_wr;

  function automatic logic sig(input int which);
    case (which)
      0:       return m_axi.awvalid;
      1:       return m_axi.wvalid;
      2:       return m_axi.arvalid;
      3:       return m_axi.bready;
      default: return m_axi.rready;
    endcase
  endfunction

  task automatic wait_hi(input int which, output bit ok);
    int cnt = 0;
    ok = 1'b1;
    while (sig(which) !== 1'b1) begin
      @(negedge clk_wr);
      cnt++;
      if (cnt > TIMEOUT) begin
        ok = 1'b0;
        total++; bad++;
        $display("FAIL timeout: channel %0d never became ready/valid, wanted 1", which);
        aborted = 1'b1;
        return;
      end
    end
  endtask

  // Reference address of burst n: base + n*(len+1)*16, wrapping at 2^32.
  function automatic logic [31:0] burst_addr(input logic [31:0] base, input int len, input int n);
    return base + 32'(n * (len + 1) * 16);
  endfunction

  task automatic aw_phase(input logic [31:0] a, input int len, input int maxdly);
    bit ok;
    logic [31:0] cap;
    wait_hi(0, ok);
    if (!ok) return;
    cap = m_axi.awaddr;
    total++;
    if ({m_axi.awaddr, m_axi.awlen, m_axi.awsize, m_axi.awburst, m_axi.awid} !==
        {a, 8'(len), 3'b100, 2'b01, 4'h0}) begin
      bad++;
      $display("FAIL aw_payload: got addr=%h len=%0d size=%b burst=%b id=%h want addr=%h len=%0d",
               m_axi.awaddr, m_axi.awlen, m_axi.awsize, m_axi.awburst, m_axi.awid, a, len);
    end
    repeat ($urandom_range(maxdly)) begin
      @(negedge clk_wr);
      total++;
      if (m_axi.awvalid !== 1'b1 || m_axi.awaddr !== cap) begin
        bad++;
        $display("FAIL aw_stable: got valid=%b addr=%h want valid=1 addr=%h", m_axi.awvalid, m_axi.awaddr, cap);
      end
    end
    m_axi.awready = 1'b1;
    @(negedge clk_wr);
    m_axi.awready = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] a, input int len, input int k, input int maxdly);
    bit ok;
    logic [31:0]  ba;
    logic [127:0] cap;
    ba = a + 32'(16 * k);
    wait_hi(1, ok);
    if (!ok) return;
    cap = m_axi.wdata;
    total++;
    if ({m_axi.wdata, m_axi.wstrb, m_axi.wlast, m_axi.wid} !== {{4{ba}}, 16'hFFFF, (k == len), 4'h0}) begin
      bad++;
      $display("FAIL w_payload: got data=%h strb=%h last=%b id=%h want data=%h last=%b",
               m_axi.wdata, m_axi.wstrb, m_axi.wlast, m_axi.wid, {4{ba}}, (k == len));
    end
    repeat ($urandom_range(maxdly)) begin
      @(negedge clk_wr);
      total++;
      if (m_axi.wvalid !== 1'b1 || m_axi.wdata !== cap) begin
        bad++;
        $display("FAIL w_stable: got valid=%b data=%h want valid=1 data=%h", m_axi.wvalid, m_axi.wdata, cap);
      end
    end
    mem[ba] = cap;
    m_axi.wready = 1'b1;
    @(negedge clk_wr);
    m_axi.wready = 1'b0;
  endtask

  task automatic b_phase(input logic [1:0] resp);
    bit ok;
    m_axi.bresp  = resp;
    m_axi.bvalid = 1'b1;
    wait_hi(3, ok);
    if (ok) @(negedge clk_wr);
    m_axi.bvalid = 1'b0;
    m_axi.bresp  = 2'b00;
  endtask

  task automatic ar_phase(input logic [31:0] a, input int len, input int maxdly);
    bit ok;
    logic [31:0] cap;
    wait_hi(2, ok);
    if (!ok) return;
    cap = m_axi.araddr;
    total++;
    if ({m_axi.araddr, m_axi.arlen, m_axi.arsize, m_axi.arburst, m_axi.arid} !==
        {a, 8'(len), 3'b100, 2'b01, 4'h0}) begin
      bad++;
      $display("FAIL ar_payload: got addr=%h len=%0d size=%b burst=%b id=%h want addr=%h len=%0d",
               m_axi.araddr, m_axi.arlen, m_axi.arsize, m_axi.arburst, m_axi.arid, a, len);
    end
    repeat ($urandom_range(maxdly)) begin
      @(negedge clk_wr);
      total++;
      if (m_axi.arvalid !== 1'b1 || m_axi.araddr !== cap) begin
        bad++;
        $display("FAIL ar_stable: got valid=%b addr=%h want valid=1 addr=%h", m_axi.arvalid, m_axi.araddr, cap);
      end
    end
    m_axi.arready = 1'b1;
    @(negedge clk_wr);
    m_axi.arready = 1'b0;
  endtask

  task automatic r_beat(input logic [31:0] ba, input bit last, input bit flip);
    bit ok;
    logic [127:0] d;
    d = mem.exists(ba) ? mem[ba] : '0;
    if (flip) d[0] = ~d[0];
    m_axi.rdata  = d;
    m_axi.rlast  = last;
    m_axi.rvalid = 1'b1;
    wait_hi(4, ok);
    if (ok) @(negedge clk_wr);
    m_axi.rvalid = 1'b0;
    m_axi.rlast  = 1'b0;
  endtask

  task automatic apply_start(input logic [31:0] base, input int len, input int num);
    @(negedge clk_wr);
    base_addr  = base;
    burst_len  = 8'(len);
    num_bursts = 8'(num);
    start      = 1'b1;
    @(negedge clk_wr);
    start      = 1'b0;
  endtask

  task automatic recover();
    rst_wr_n = 1'b0;
    m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.arready = 1'b0;
    m_axi.bvalid  = 1'b0; m_axi.rvalid = 1'b0;
    @(negedge clk_wr);
    rst_wr_n = 1'b1;
  endtask

  // Full write-then-read run; expected error count comes from the injected faults.
  task automatic do_run(input logic [31:0] base, input int len, input int num,
                        input int b_err_burst, input int r_err_beat, input int maxdly);
    int exp_err = 0;
    aborted = 1'b0;
    mem.delete();
    apply_start(base, len, num);
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL start_ack: got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    for (int n = 0; n < num; n++) begin
      aw_phase(burst_addr(base, len, n), len, maxdly);
      for (int k = 0; k <= len; k++) if (!aborted) w_beat(burst_addr(base, len, n), len, k, maxdly);
      if (aborted) begin recover(); return; end
      if (n == b_err_burst) exp_err++;
      b_phase((n == b_err_burst) ? 2'b10 : 2'b00);
    end
    for (int n = 0; n < num; n++) begin
      ar_phase(burst_addr(base, len, n), len, maxdly);
      for (int k = 0; k <= len; k++) begin
        if (aborted) break;
        if (n * (len + 1) + k == r_err_beat) exp_err++;
        r_beat(burst_addr(base, len, n) + 32'(16 * k), (k == len), (n * (len + 1) + k == r_err_beat));
        repeat ($urandom_range(1)) @(negedge clk_wr);
      end
      if (aborted) begin recover(); return; end
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || err_count !== 16'(exp_err) || pass !== (exp_err == 0)) begin
      bad++;
      $display("FAIL run_result: got done=%b busy=%b err=%0d pass=%b want done=1 busy=0 err=%0d pass=%b",
               done, busy, err_count, pass, exp_err, (exp_err == 0));
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({m_axi.awvalid, m_axi.wvalid, m_axi.arvalid, m_axi.bready, m_axi.rready,
         busy, done, pass, err_count} !== 25'd0) begin
      bad++;
      $display("FAIL %s: got aw=%b w=%b ar=%b bready=%b rready=%b busy=%b done=%b pass=%b err=%0d want all 0",
               name, m_axi.awvalid, m_axi.wvalid, m_axi.arvalid, m_axi.bready, m_axi.rready,
               busy, done, pass, err_count);
    end
  endtask

  task automatic test_reset();
    rst_wr_n = 1'b0;
    repeat (2) @(negedge clk_wr);
    check_all_zero("reset_state");
    rst_wr_n = 1'b1;
  endtask

  task automatic test_basic();
    do_run(32'h0000_1000, 3, 2, -1, -1, 0);
  endtask

  task automatic test_errors();
    do_run(32'h0000_1000, 3, 2, 1, 5, 0);
  endtask

  task automatic test_backpressure();
    do_run(32'h0000_1000, 3, 2, -1, -1, 5);
  endtask

  task automatic test_zero_bursts();
    apply_start(32'h0000_4000, 2, 0);
    total++;
    if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0 || err_count !== 16'd0) begin
      bad++;
      $display("FAIL zero_bursts: got done=%b pass=%b busy=%b err=%0d want done=1 pass=1 busy=0 err=0",
               done, pass, busy, err_count);
    end
    repeat (3) begin
      @(negedge clk_wr);
      total++;
      if ({m_axi.awvalid, m_axi.wvalid, m_axi.arvalid} !== 3'b000) begin
        bad++;
        $display("FAIL zero_no_valid: got aw=%b w=%b ar=%b want 000", m_axi.awvalid, m_axi.wvalid, m_axi.arvalid);
      end
    end
  endtask

  task automatic test_reset_midburst();
    bit ok;
    aborted = 1'b0;
    apply_start(32'h0000_2000, 3, 2);
    aw_phase(32'h0000_2000, 3, 0);
    w_beat(32'h0000_2000, 3, 0, 0);
    w_beat(32'h0000_2000, 3, 1, 0);
    wait_hi(1, ok);
    rst_wr_n = 1'b0;
    #1;
    check_all_zero("reset_midburst");
    @(negedge clk_wr);
    rst_wr_n = 1'b1;
    do_run(32'h0000_2000, 3, 2, -1, -1, 1);
  endtask

  task automatic test_wrap();
    do_run(32'hFFFF_FFE0, 1, 2, -1, -1, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      int len, num, berr, rerr;
      len  = int'($urandom_range(7));
      num  = int'($urandom_range(3, 1));
      berr = ($urandom_range(1) == 1) ? int'($urandom_range(num - 1)) : -1;
      rerr = ($urandom_range(1) == 1) ? int'($urandom_range(num * (len + 1) - 1)) : -1;
      do_run($urandom, len, num, berr, rerr, 3);
    end
  endtask

  initial begin
    m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.arready = 1'b0;
    m_axi.bid = '0; m_axi.bresp = 2'b00; m_axi.bvalid = 1'b0;
    m_axi.rid = '0; m_axi.rdata = '0; m_axi.rresp = 2'b00; m_axi.rlast = 1'b0; m_axi.rvalid = 1'b0;
    test_reset();
    test_basic();
    test_errors();
    test_backpressure();
    test_zero_bursts();
    test_basic();
    test_reset_midburst();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
